// File: rtl/red_pitaya_pll_drp_pkg.sv
// PLLE2_ADV DRP reconfiguration: shared types, register map, merge helper.
// Used by red_pitaya_pll_drp_ctrl and red_pitaya_drp_rmw.
package red_pitaya_pll_drp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RMW,
    S_ACCEPT,
    S_LOCK_WAIT,
    S_FLUSH
  } ctrl_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_READ,
    R_READ_WAIT,
    R_WRITE,
    R_WRITE_WAIT
  } rmw_state_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] mask;
    logic        last;
  } drp_word_t;

  localparam logic [6:0] ADDR_CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] ADDR_CLKOUT0_REG2  = 7'h09;
  localparam logic [6:0] ADDR_CLKOUT1_REG1  = 7'h0A;
  localparam logic [6:0] ADDR_CLKOUT1_REG2  = 7'h0B;
  localparam logic [6:0] ADDR_CLKOUT2_REG1  = 7'h0C;
  localparam logic [6:0] ADDR_CLKOUT2_REG2  = 7'h0D;
  localparam logic [6:0] ADDR_CLKOUT3_REG1  = 7'h0E;
  localparam logic [6:0] ADDR_CLKOUT3_REG2  = 7'h0F;
  localparam logic [6:0] ADDR_CLKOUT4_REG1  = 7'h10;
  localparam logic [6:0] ADDR_CLKOUT4_REG2  = 7'h11;
  localparam logic [6:0] ADDR_CLKOUT5_REG1  = 7'h12;
  localparam logic [6:0] ADDR_CLKOUT5_REG2  = 7'h13;
  localparam logic [6:0] ADDR_CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] ADDR_CLKFBOUT_REG2 = 7'h15;
  localparam logic [6:0] ADDR_DIVCLK        = 7'h16;
  localparam logic [6:0] ADDR_LOCK_REG1     = 7'h18;
  localparam logic [6:0] ADDR_LOCK_REG2     = 7'h19;
  localparam logic [6:0] ADDR_LOCK_REG3     = 7'h1A;
  localparam logic [6:0] ADDR_POWER         = 7'h28;
  localparam logic [6:0] ADDR_FILT_REG1     = 7'h4E;
  localparam logic [6:0] ADDR_FILT_REG2     = 7'h4F;

  // mask bit 1 keeps the current register bit
  function automatic logic [15:0] drp_merge(
    input logic [15:0] cur,
    input logic [15:0] data,
    input logic [15:0] mask
  );
    return (cur & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/red_pitaya_drp_rmw.sv
// Single-register DRP read/merge/write engine with DRDY timeout.
// Ports: start/addr/data/mask in, done/timeout pulses out, DRP port.
module red_pitaya_drp_rmw
  import red_pitaya_pll_drp_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [6:0]  addr,
  input  logic [15:0] data,
  input  logic [15:0] mask,
  output logic        done,
  output logic        timeout,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  localparam int CW = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(DRDY_TIMEOUT);
  localparam logic [CW-1:0] CEND = CW'(DRDY_TIMEOUT - 1);

  rmw_state_t    st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   di_q, di_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st   <= R_IDLE;
      cnt  <= '0;
      di_q <= '0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      di_q <= di_nxt;
    end
  end

  assign drp_di = di_q;

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    di_nxt    = di_q;
    done      = 1'b0;
    timeout   = 1'b0;
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    drp_daddr = '0;
    unique case (st)
      R_IDLE: begin
        if (start) st_nxt = R_READ;
      end
      R_READ: begin
        drp_den   = 1'b1;
        drp_daddr = addr;
        cnt_nxt   = '0;
        st_nxt    = R_READ_WAIT;
      end
      R_READ_WAIT: begin
        if (drp_drdy) begin
          di_nxt = drp_merge(drp_do, data, mask);
          st_nxt = R_WRITE;
        end else if (cnt == CEND) begin
          timeout = 1'b1;
          st_nxt  = R_IDLE;
        end else begin
          cnt_nxt = (cnt == CMAX) ? cnt : cnt + 1'b1;
        end
      end
      R_WRITE: begin
        drp_den   = 1'b1;
        drp_dwe   = 1'b1;
        drp_daddr = addr;
        cnt_nxt   = '0;
        st_nxt    = R_WRITE_WAIT;
      end
      R_WRITE_WAIT: begin
        if (drp_drdy) begin
          done   = 1'b1;
          st_nxt = R_IDLE;
        end else if (cnt == CEND) begin
          timeout = 1'b1;
          st_nxt  = R_IDLE;
        end else begin
          cnt_nxt = (cnt == CMAX) ? cnt : cnt + 1'b1;
        end
      end
      default: st_nxt = R_IDLE;
    endcase
  end

endmodule

// File: rtl/red_pitaya_pll_drp_ctrl.sv
// PLLE2_ADV DRP burst sequencer: PLL reset hold, masked RMW, lock wait.
// Ports: host wr_* handshake, busy/done/err_*, DRP port, pll_rst/pll_locked.
module red_pitaya_pll_drp_ctrl
  import red_pitaya_pll_drp_pkg::*;
#(
  parameter int RST_HOLD     = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [15:0] wr_mask,
  input  logic        wr_last,
  output logic        busy,
  output logic        done,
  output logic        err_drdy,
  output logic        err_lock,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [HW-1:0] HEND = HW'(RST_HOLD - 1);
  localparam logic [LW-1:0] LEND = LW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_TIMEOUT);

  ctrl_state_t   st, st_nxt;
  drp_word_t     wrd, wrd_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [LW-1:0] lcnt, lcnt_nxt;
  logic          pll_rst_nxt, busy_nxt, done_nxt;
  logic          err_drdy_nxt, err_lock_nxt;
  logic          live, acc;
  logic          rmw_start, rmw_done, rmw_to;

  // keeps wr_ready low until the first clock after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) live <= 1'b0;
    else       live <= 1'b1;
  end

  assign wr_ready = live & ((st == S_IDLE) |
                            (st == S_ACCEPT) |
                            (st == S_FLUSH));
  assign acc = wr_valid & wr_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= S_IDLE;
      wrd      <= '0;
      hcnt     <= '0;
      lcnt     <= '0;
      pll_rst  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_drdy <= 1'b0;
      err_lock <= 1'b0;
    end else begin
      st       <= st_nxt;
      wrd      <= wrd_nxt;
      hcnt     <= hcnt_nxt;
      lcnt     <= lcnt_nxt;
      pll_rst  <= pll_rst_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err_drdy <= err_drdy_nxt;
      err_lock <= err_lock_nxt;
    end
  end

  always_comb begin
    st_nxt       = st;
    wrd_nxt      = wrd;
    hcnt_nxt     = hcnt;
    lcnt_nxt     = lcnt;
    pll_rst_nxt  = pll_rst;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_drdy_nxt = err_drdy;
    err_lock_nxt = err_lock;
    rmw_start    = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (acc) begin
          wrd_nxt      = drp_word_t'{wr_addr, wr_data,
                                     wr_mask, wr_last};
          err_drdy_nxt = 1'b0;
          err_lock_nxt = 1'b0;
          busy_nxt     = 1'b1;
          pll_rst_nxt  = 1'b1;
          hcnt_nxt     = '0;
          st_nxt       = S_RST_HOLD;
        end
      end
      S_RST_HOLD: begin
        if (hcnt == HEND) begin
          rmw_start = 1'b1;
          st_nxt    = S_RMW;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      S_RMW: begin
        if (rmw_done) begin
          if (wrd.last) begin
            pll_rst_nxt = 1'b0;
            lcnt_nxt    = '0;
            st_nxt      = S_LOCK_WAIT;
          end else begin
            st_nxt = S_ACCEPT;
          end
        end else if (rmw_to) begin
          err_drdy_nxt = 1'b1;
          pll_rst_nxt  = 1'b0;
          lcnt_nxt     = '0;
          st_nxt       = wrd.last ? S_LOCK_WAIT : S_FLUSH;
        end
      end
      S_ACCEPT: begin
        if (acc) begin
          wrd_nxt   = drp_word_t'{wr_addr, wr_data,
                                  wr_mask, wr_last};
          rmw_start = 1'b1;
          st_nxt    = S_RMW;
        end
      end
      S_FLUSH: begin
        if (acc && wr_last) begin
          lcnt_nxt = '0;
          st_nxt   = S_LOCK_WAIT;
        end
      end
      S_LOCK_WAIT: begin
        if (pll_locked) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
          st_nxt   = S_IDLE;
        end else if (lcnt == LEND) begin
          err_lock_nxt = 1'b1;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          st_nxt       = S_IDLE;
        end else begin
          lcnt_nxt = (lcnt == LMAX) ? lcnt : lcnt + 1'b1;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  red_pitaya_drp_rmw #(
    .DRDY_TIMEOUT(DRDY_TIMEOUT)
  ) u_rmw (
    .clk      (clk),
    .rstn     (rstn),
    .start    (rmw_start),
    .addr     (wrd.addr),
    .data     (wrd.data),
    .mask     (wrd.mask),
    .done     (rmw_done),
    .timeout  (rmw_to),
    .drp_daddr(drp_daddr),
    .drp_den  (drp_den),
    .drp_dwe  (drp_dwe),
    .drp_di   (drp_di),
    .drp_do   (drp_do),
    .drp_drdy (drp_drdy)
  );

endmodule

// File: tb/tb_red_pitaya_pll_drp_ctrl.sv
// Directed bench for red_pitaya_pll_drp_ctrl with DRP and PLL lock models.
// Ports: none.
module tb_red_pitaya_pll_drp_ctrl;

  logic        clk;
  logic        rstn;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] wr_mask;
  logic        wr_last;
  logic        busy;
  logic        done;
  logic        err_drdy;
  logic        err_lock;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        pll_rst;
  logic        pll_locked;

  red_pitaya_pll_drp_ctrl #(
    .RST_HOLD    (8),
    .DRDY_TIMEOUT(64),
    .LOCK_TIMEOUT(512)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .wr_last   (wr_last),
    .busy      (busy),
    .done      (done),
    .err_drdy  (err_drdy),
    .err_lock  (err_lock),
    .drp_daddr (drp_daddr),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy),
    .pll_rst   (pll_rst),
    .pll_locked(pll_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:127];
  logic [6:0]  op_addr [$];
  logic        op_we [$];
  logic [15:0] op_di [$];
  int lat, rst_run, lock_cnt, first_hold, lock_delay;
  logic force_drdy, kill_next, lock_en;

  int w, w2, i, k, bad;

  logic [6:0]  t2_addr [3] = '{7'h14, 7'h15, 7'h16};
  logic [15:0] t2_data [3] = '{16'h0082, 16'h0400, 16'h2082};
  logic [15:0] t2_mask [3] = '{16'hF000, 16'h00FF, 16'h0000};
  logic [15:0] t2_wr   [3] = '{16'h1082, 16'h04C0, 16'h2082};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRP register file + PLL lock model, all driven on the falling edge
  always @(negedge clk) begin
    drp_drdy = force_drdy;
    if (lat > 0) begin
      lat--;
      if (lat == 0) drp_drdy = 1'b1;
    end
    if (drp_den) begin
      if (op_addr.size() == 0) first_hold = rst_run;
      op_addr.push_back(drp_daddr);
      op_we.push_back(drp_dwe);
      op_di.push_back(drp_di);
      if (drp_dwe) mem[drp_daddr] = drp_di;
      else         drp_do = mem[drp_daddr];
      if (kill_next) kill_next = 1'b0;
      else           lat = 3;
    end
    if (!pll_rst)      rst_run = 0;
    else if (!drp_den) rst_run++;
    if (pll_rst || !rstn) begin
      lock_cnt   = 0;
      pll_locked = 1'b0;
    end else if (lock_en) begin
      if (lock_cnt >= lock_delay) pll_locked = 1'b1;
      else                        lock_cnt++;
    end
  end

  task automatic clr_log();
    op_addr.delete();
    op_we.delete();
    op_di.delete();
    first_hold = -1;
  endtask

  task automatic send(input logic [6:0] a, input logic [15:0] d,
                      input logic [15:0] m, input logic l,
                      output int waits);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    wr_last  = l;
    waits    = 0;
    while (!wr_ready && waits < 400) begin
      @(negedge clk);
      waits++;
    end
    chk("send_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int j = 0; j < budget; j++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    wr_mask = 0; wr_last = 0;
    drp_do = 0; drp_drdy = 0; pll_locked = 0;
    force_drdy = 0; kill_next = 0; lock_en = 1; lock_delay = 100;
    lat = 0; rst_run = 0; lock_cnt = 0; first_hold = -1;
    for (int j = 0; j < 128; j++) mem[j] = 16'h0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, done, err_drdy, err_lock, pll_rst,
                     wr_ready, drp_den, drp_dwe}, 0);
    chk("rst_drp", {drp_daddr, drp_di}, 0);
    rstn = 1; #1;
    chk("rst_rdy_pre", wr_ready, 0);
    @(negedge clk);
    chk("rst_rdy_post", wr_ready, 1);

    // single-word burst
    mem[7'h08] = 16'h1145;
    clr_log();
    send(7'h08, 16'h1041, 16'h1000, 1'b1, w);
    chk("t1_busy", busy, 1);
    wait_done(2000);
    chk("t1_busy_end", busy, 0);
    chk("t1_err", {err_drdy, err_lock}, 0);
    chk("t1_locked", pll_locked, 1);
    chk("t1_hold", first_hold, 8);
    chk("t1_nops", op_addr.size(), 2);
    chk("t1_rd", {op_we[0], op_addr[0]}, {1'b0, 7'h08});
    chk("t1_wr", {op_we[1], op_addr[1], op_di[1]},
        {1'b1, 7'h08, 16'h1041});
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // stray drdy in IDLE
    @(negedge clk);
    force_drdy = 1;
    @(negedge clk);
    force_drdy = 0;
    repeat (2) @(negedge clk);
    chk("st_idle", {busy, done, drp_den, wr_ready}, 4'b0001);
    chk("st_di", drp_di, 16'h1041);

    // host offers word 2 during RST_HOLD
    mem[7'h18] = 16'h0100;
    mem[7'h19] = 16'h0200;
    clr_log();
    send(7'h18, 16'h00FF, 16'hFF00, 1'b0, w);
    send(7'h19, 16'h3300, 16'h00FF, 1'b1, w2);
    chk("t6_wait", w2, 15);
    wait_done(2000);
    chk("t6_nops", op_addr.size(), 4);
    chk("t6_op0", {op_we[0], op_addr[0]}, {1'b0, 7'h18});
    chk("t6_op1", {op_we[1], op_addr[1], op_di[1]},
        {1'b1, 7'h18, 16'h01FF});
    chk("t6_op2", {op_we[2], op_addr[2]}, {1'b0, 7'h19});
    chk("t6_op3", {op_we[3], op_addr[3], op_di[3]},
        {1'b1, 7'h19, 16'h3300});

    // 3-word burst with host stalls
    mem[7'h14] = 16'h1041;
    mem[7'h15] = 16'h00C0;
    mem[7'h16] = 16'h1041;
    clr_log();
    for (int j = 0; j < 3; j++) begin
      send(t2_addr[j], t2_data[j], t2_mask[j], j == 2, w);
      if (j < 2) begin
        i = 0;
        while (!wr_ready && i < 200) begin
          @(negedge clk);
          i++;
        end
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (!pll_rst || !wr_ready) bad++;
        end
        chk($sformatf("t2_stall%0d", j), bad, 0);
      end
    end
    wait_done(2000);
    chk("t2_nops", op_addr.size(), 6);
    for (int j = 0; j < 6; j++)
      chk($sformatf("t2_op%0d", j), {op_we[j], op_addr[j]},
          {j[0], t2_addr[j/2]});
    for (int j = 0; j < 3; j++)
      chk($sformatf("t2_di%0d", j), op_di[2*j+1], t2_wr[j]);
    chk("t2_err", {err_drdy, err_lock}, 0);

    // DRDY never arrives on word 1 of 3
    lock_delay = 10;
    mem[7'h09] = 16'h0002;
    clr_log();
    kill_next = 1;
    send(7'h08, 16'hAAAA, 16'h0000, 1'b0, w);
    i = 0;
    while (!drp_den && i < 50) begin
      @(negedge clk);
      i++;
    end
    k = 0;
    while (!err_drdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t3_drdy_lat", k, 65);
    chk("t3_pll_rst", pll_rst, 0);
    send(7'h09, 16'h5555, 16'h0000, 1'b0, w);
    chk("t3_flush1", w, 0);
    send(7'h0A, 16'h5555, 16'h0000, 1'b1, w);
    chk("t3_flush2", w, 0);
    wait_done(500);
    chk("t3_err", {err_drdy, err_lock}, 2'b10);
    chk("t3_nops", op_addr.size(), 1);
    chk("t3_mem9", mem[7'h09], 16'h0002);
    chk("t3_busy", busy, 0);

    // PLL never locks
    lock_en = 0;
    mem[7'h28] = 16'h0000;
    clr_log();
    send(7'h28, 16'h0001, 16'hFFFE, 1'b1, w);
    chk("t4_errd_clr", err_drdy, 0);
    i = 0;
    while (pll_rst && i < 200) begin
      @(negedge clk);
      i++;
    end
    k = 0;
    while (!done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("t4_lock_lat", k, 512);
    chk("t4_flags", {err_lock, err_drdy, busy}, 3'b100);
    chk("t4_wr", op_di[1], 16'h0001);
    @(negedge clk);
    chk("t4_sticky", {done, err_lock}, 2'b01);
    lock_en = 1;

    // async reset during WRITE_WAIT
    clr_log();
    send(7'h4E, 16'h0800, 16'h0000, 1'b1, w);
    chk("t5_errl_clr", err_lock, 0);
    i = 0;
    while (!(drp_den && drp_dwe) && i < 100) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    rstn = 0; #1;
    chk("t5_rst_outs", {busy, done, err_drdy, err_lock, pll_rst,
                        wr_ready, drp_den, drp_dwe}, 0);
    chk("t5_rst_drp", {drp_daddr, drp_di}, 0);
    repeat (5) @(negedge clk);
    rstn = 1;
    repeat (3) @(negedge clk);
    chk("t5_idle", {busy, wr_ready}, 2'b01);
    mem[7'h4F] = 16'h8000;
    clr_log();
    send(7'h4F, 16'h0123, 16'hF000, 1'b1, w);
    wait_done(2000);
    chk("t5_nops", op_addr.size(), 2);
    chk("t5_wr", {op_we[1], op_addr[1], op_di[1]},
        {1'b1, 7'h4F, 16'h8123});
    chk("t5_err", {err_drdy, err_lock, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
